// File: rtl/grn_node_multi.sv
// Multi-channel Boolean gene-network node: per-channel OR/AND update with run-time divider,
// change pulses and steady-state detection. Define GRN_FLIP_CNT_EN to add per-channel flip counters.
module grn_node_multi #(
   parameter int NUM_CH  = 2,
   parameter int NUM_IN  = 2,
   parameter int DIV_W   = 4,
   parameter int STB_W   = 8,
   parameter int STB_THR = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       reset_nos,
   input  logic                       init_state,
   input  logic                       func_and,
   input  logic [NUM_CH-1:0]          start,
   input  logic [NUM_CH*NUM_IN-1:0]   terms,
   input  logic [NUM_CH*DIV_W-1:0]    div_cfg,
   output logic [NUM_CH-1:0]          s,
   output logic [NUM_CH-1:0]          limk,
   output logic [NUM_CH-1:0]          changed,
   output logic [NUM_CH-1:0]          stable,
   output logic                       all_stable
`ifdef GRN_FLIP_CNT_EN
   ,
   output logic [NUM_CH*16-1:0]       flip_cnt
`endif
);

   localparam logic [STB_W-1:0] STB_MAX = {STB_W{1'b1}};
   localparam logic [STB_W-1:0] STB_LIM = STB_W'(STB_THR);

   logic [NUM_CH-1:0] s_q, s_d;
   logic [NUM_CH-1:0] chg_q, chg_d;
   logic [NUM_CH-1:0] f_s;
   logic [DIV_W-1:0]  ph_q [NUM_CH];
   logic [DIV_W-1:0]  ph_d [NUM_CH];
   logic [STB_W-1:0]  sc_q [NUM_CH];
   logic [STB_W-1:0]  sc_d [NUM_CH];

   // Combine each channel's regulator terms according to the selected mode
   always_comb begin
      f_s = {NUM_CH{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
         if (func_and) begin
            f_s[c] = &terms[c*NUM_IN +: NUM_IN];
         end else begin
            f_s[c] = |terms[c*NUM_IN +: NUM_IN];
         end
      end
   end

   // Per-channel next state: network re-init beats start; ph==0 means this start updates
   always_comb begin
      s_d   = s_q;
      chg_d = {NUM_CH{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
         ph_d[c] = ph_q[c];
         sc_d[c] = sc_q[c];
         if (reset_nos) begin
            s_d[c]  = init_state;
            ph_d[c] = {DIV_W{1'b0}};
            sc_d[c] = {STB_W{1'b0}};
         end else if (start[c]) begin
            if (ph_q[c] == {DIV_W{1'b0}}) begin
               s_d[c]  = f_s[c];
               ph_d[c] = div_cfg[c*DIV_W +: DIV_W];
               if (f_s[c] != s_q[c]) begin
                  chg_d[c] = 1'b1;
                  sc_d[c]  = {STB_W{1'b0}};
               end else if (sc_q[c] != STB_MAX) begin
                  sc_d[c] = sc_q[c] + STB_W'(1);
               end else begin
                  sc_d[c] = sc_q[c];
               end
            end else begin
               ph_d[c] = ph_q[c] - DIV_W'(1);
            end
         end else begin
            ph_d[c] = ph_q[c];
         end
      end
   end

   // State, phase, stability and change-pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q   <= {NUM_CH{1'b0}};
         chg_q <= {NUM_CH{1'b0}};
         for (int c = 0; c < NUM_CH; c++) begin
            ph_q[c] <= {DIV_W{1'b0}};
            sc_q[c] <= {STB_W{1'b0}};
         end
      end else begin
         s_q   <= s_d;
         chg_q <= chg_d;
         for (int c = 0; c < NUM_CH; c++) begin
            ph_q[c] <= ph_d[c];
            sc_q[c] <= sc_d[c];
         end
      end
   end

   // Stability flags decoded from the run-length registers
   always_comb begin
      stable = {NUM_CH{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
         stable[c] = (sc_q[c] >= STB_LIM);
      end
   end

   assign all_stable = &stable;
   assign s          = s_q;
   assign limk       = s_q;
   assign changed    = chg_q;

`ifdef GRN_FLIP_CNT_EN
   logic [15:0] flip_q [NUM_CH];

   // Flip counters survive reset_nos so flips accumulate across network re-inits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            flip_q[c] <= 16'd0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (chg_d[c] && (flip_q[c] != 16'hFFFF)) begin
               flip_q[c] <= flip_q[c] + 16'd1;
            end
         end
      end
   end

   // Flatten counters onto the export port
   always_comb begin
      flip_cnt = {(NUM_CH*16){1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
         flip_cnt[c*16 +: 16] = flip_q[c];
      end
   end
`endif

endmodule

// File: tb/tb_grn_node_multi.sv
// Bench for grn_node_multi: directed scenarios then random traffic, all checked against a
// behavioural model that counts starts per update period and tracks run lengths as integers.
module tb_grn_node_multi;

   localparam int NCH = 2;
   localparam int NIN = 2;
   localparam int DW  = 4;
   localparam int THR = 16;

   logic                clk = 1'b0;
   logic                rst_n, reset_nos, init_state, func_and;
   logic [NCH-1:0]      start;
   logic [NCH*NIN-1:0]  terms;
   logic [NCH*DW-1:0]   div_cfg;
   logic [NCH-1:0]      s, limk, changed, stable;
   logic                all_stable;
`ifdef GRN_FLIP_CNT_EN
   logic [NCH*16-1:0]   flip_cnt;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [NCH-1:0] s_m, chg_m;
   int since_m  [NCH];
   int period_m [NCH];
   int run_m    [NCH];
   int flips_m  [NCH];

   grn_node_multi #(.NUM_CH(NCH), .NUM_IN(NIN), .DIV_W(DW), .STB_W(8), .STB_THR(THR)) dut (
      .clk(clk), .rst_n(rst_n), .reset_nos(reset_nos), .init_state(init_state),
      .func_and(func_and), .start(start), .terms(terms), .div_cfg(div_cfg),
      .s(s), .limk(limk), .changed(changed), .stable(stable), .all_stable(all_stable)
`ifdef GRN_FLIP_CNT_EN
      , .flip_cnt(flip_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic model_reset(input bit full);
      s_m   = '0;
      chg_m = '0;
      for (int c = 0; c < NCH; c++) begin
         since_m[c]  = 0;
         period_m[c] = 0;
         run_m[c]    = 0;
         if (full) flips_m[c] = 0;
      end
   endtask

   // One clock of the model, using the inputs present at the edge
   task automatic model_clock();
      logic [NIN-1:0] t;
      logic f;
      chg_m = '0;
      if (!rst_n) begin
         model_reset(1'b1);
      end else if (reset_nos) begin
         model_reset(1'b0);
         s_m = {NCH{init_state}};
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (start[c]) begin
               since_m[c]++;
               if (since_m[c] > period_m[c]) begin
                  t = terms[c*NIN +: NIN];
                  f = func_and ? (t == {NIN{1'b1}}) : (t != '0);
                  if (f != s_m[c]) begin
                     chg_m[c] = 1'b1;
                     run_m[c] = 0;
                     if (flips_m[c] < 65535) flips_m[c]++;
                  end else begin
                     run_m[c]++;
                  end
                  s_m[c]      = f;
                  since_m[c]  = 0;
                  period_m[c] = int'(div_cfg[c*DW +: DW]);
               end
            end
         end
      end
   endtask

   task automatic check_all();
      logic [NCH-1:0] stb_e;
      for (int c = 0; c < NCH; c++) stb_e[c] = (run_m[c] >= THR);
      total++;
      assert (s === s_m) else begin bad++; $error("FAIL s got=%b exp=%b", s, s_m); end
      total++;
      assert (limk === s_m) else begin bad++; $error("FAIL limk got=%b exp=%b", limk, s_m); end
      total++;
      assert (changed === chg_m) else begin bad++; $error("FAIL changed got=%b exp=%b", changed, chg_m); end
      total++;
      assert (stable === stb_e) else begin bad++; $error("FAIL stable got=%b exp=%b", stable, stb_e); end
      total++;
      assert (all_stable === (&stb_e)) else begin bad++; $error("FAIL all_stable got=%b exp=%b", all_stable, &stb_e); end
`ifdef GRN_FLIP_CNT_EN
      for (int c = 0; c < NCH; c++) begin
         total++;
         assert (flip_cnt[c*16 +: 16] === 16'(flips_m[c]))
            else begin bad++; $error("FAIL flip_cnt[%0d] got=%0d exp=%0d", c, flip_cnt[c*16 +: 16], flips_m[c]); end
      end
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_clock();
      check_all();
   endtask

   initial begin
      rst_n = 1'b0; reset_nos = 1'b0; init_state = 1'b0; func_and = 1'b0;
      start = '0; terms = '0; div_cfg = '0;
      model_reset(1'b1);
      #12;
      check_all();
      rst_n = 1'b1;
      tick();

      // Divider 1 on ch0, 0 on ch1, OR of all-ones terms
      div_cfg = {4'd0, 4'd1}; terms = 4'b1111; func_and = 1'b0;
      reset_nos = 1'b1; init_state = 1'b0;
      tick();
      reset_nos = 1'b0; start = 2'b11;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         assert (changed === ((i == 0) ? 2'b11 : 2'b00))
            else begin bad++; $error("FAIL div_chg[%0d] got=%b", i, changed); end
      end
      total++;
      assert (s === 2'b11) else begin bad++; $error("FAIL div_s got=%b exp=11", s); end

      // AND mode
      reset_nos = 1'b1; init_state = 1'b0; start = '0; div_cfg = '0;
      tick();
      reset_nos = 1'b0; func_and = 1'b1; terms = 4'b1010; start = 2'b11;
      tick();
      total++;
      assert (s === 2'b00) else begin bad++; $error("FAIL and_lo got=%b exp=00", s); end
      terms = 4'b1111;
      tick();
      total++;
      assert (changed === 2'b11) else begin bad++; $error("FAIL and_hi got=%b exp=11", changed); end

      // Stability: hold terms then flip ch0 to unstable
      for (int i = 0; i < 17; i++) tick();
      total++;
      assert (stable === 2'b11) else begin bad++; $error("FAIL stb_up got=%b exp=11", stable); end
      terms = 4'b1101;
      tick();
      total++;
      assert (stable === 2'b10 && all_stable === 1'b0)
         else begin bad++; $error("FAIL stb_dn got=%b/%b exp=10/0", stable, all_stable); end

      // reset_nos wins over start, then next start updates at once
      reset_nos = 1'b1; init_state = 1'b1; func_and = 1'b0; terms = 4'b0000;
      tick();
      total++;
      assert (s === 2'b11 && changed === 2'b00)
         else begin bad++; $error("FAIL nos_start got=%b/%b exp=11/00", s, changed); end
      reset_nos = 1'b0; div_cfg = {4'd3, 4'd3};
      tick();
      total++;
      assert (s === 2'b00) else begin bad++; $error("FAIL nos_next got=%b exp=00", s); end

      // Divider change mid-countdown
      tick();
      div_cfg = '0;
      for (int i = 0; i < 8; i++) begin
         terms = ~terms;
         tick();
      end

      // Flip count accumulation across reset_nos
      div_cfg = '0; terms = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         tick();
         terms = ~terms;
      end
      reset_nos = 1'b1; start = '0;
      tick();
      reset_nos = 1'b0;

      // Async reset mid-period
      div_cfg = {4'd5, 4'd5}; start = 2'b11; terms = 4'b0101;
      tick();
      tick();
      #3 rst_n = 1'b0;
      #1;
      model_reset(1'b1);
      check_all();
      total++;
      assert (s === 2'b00 && changed === 2'b00)
         else begin bad++; $error("FAIL async_rst got=%b/%b exp=00/00", s, changed); end
      @(negedge clk);
      rst_n = 1'b1; start = '0;
      tick();

`ifdef GRN_FLIP_CNT_EN
      div_cfg = '0; start = 2'b01; terms = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         terms = ~terms & 4'b0001;
      end
      reset_nos = 1'b1; start = '0;
      tick();
      reset_nos = 1'b0;
      total++;
      assert (flip_cnt[15:0] === 16'd3)
         else begin bad++; $error("FAIL flip_keep got=%0d exp=3", flip_cnt[15:0]); end
`endif

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         start      = NCH'($urandom);
         terms      = (NCH*NIN)'($urandom);
         func_and   = 1'($urandom);
         init_state = 1'($urandom);
         reset_nos  = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 3) == 0)
            div_cfg = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
